// File: rtl/bin_sched_pkg.sv
// Shared types and helpers for the binary line-buffer scheduler.
package bin_sched_pkg;

    // Widest bank the scheduler supports; one-hot helper is sized to it.
    localparam int ROW_MAX = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VBLANK,
        S_PRIME,
        S_RUN
    } state_t;

    // One-hot write-enable pattern for a line pointer.
    function automatic logic [ROW_MAX-1:0] onehot_ptr(input logic [2:0] ptr);
        onehot_ptr = ROW_MAX'(1) << ptr;
    endfunction

endpackage

// File: rtl/bin_line_sched_sync_edge.sv
// Rising-edge detector: o_rise is high on the clk where i_sig is 1 and was 0 the clk before.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d;

    // Previous-cycle copy of the input; starts at 0 so a high level after reset counts as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sig_d <= 1'b0;
        else     r_sig_d <= i_sig;
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/bin_line_sched.sv
// Line-buffer bank sequencer: shared RAM address, one-hot write enables and read-rotation
// select derived from hsync/vsync/de. Tracks frame-start priming and flags line overruns.
module bin_line_sched
    import bin_sched_pkg::*;
#(
    parameter logic [11:0] H_ACT = 12'd1280,
    parameter logic [11:0] V_ACT = 12'd720,
    parameter int          ROW   = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          hsync,
    input  logic                                          vsync,
    input  logic                                          de,
    output logic [((H_ACT > 1) ? $clog2(H_ACT) : 1)-1:0]  ram_addr,
    output logic [ROW-1:0]                                ram_wen,
    output logic [$clog2(ROW)-1:0]                        rd_sel,
    output logic                                          win_valid,
    output logic [((V_ACT > 1) ? $clog2(V_ACT) : 1)-1:0]  line_cnt,
    output logic                                          frame_sop,
    output logic                                          ovf
);

    localparam int AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int PW = $clog2(ROW);

    localparam logic [AW-1:0] ADDR_LAST  = AW'(H_ACT - 12'd1);
    localparam logic [YW-1:0] LINE_LAST  = YW'(V_ACT - 12'd1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(ROW - 1);
    localparam logic [YW-1:0] PRIME_LAST = YW'(ROW - 2);

    if (ROW < 2 || ROW > ROW_MAX || H_ACT == 12'd0 || V_ACT == 12'd0) begin : g_bad_param
        $error("bin_line_sched: ROW must be 2..8 and H_ACT/V_ACT non-zero");
    end

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [AW-1:0] r_addr;
    logic          r_full;
    logic [YW-1:0] r_line;
    logic          r_sop_done;

    logic          w_hs_rise;
    logic [PW-1:0] w_ptr_eff;
    logic [AW-1:0] w_addr_eff;
    logic          w_full_eff;
    logic [YW-1:0] w_line_eff;
    logic          w_wr;
    logic          w_ovf_hit;
    logic          w_to_run;
    logic          w_run_nxt;
    logic          w_sop;

    sync_edge u_hs_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (hsync),
        .o_rise (w_hs_rise)
    );

    // Line-start view of the counters: a coincident hs_rise takes effect before the de write.
    always_comb begin
        w_ptr_eff  = r_ptr;
        w_addr_eff = r_addr;
        w_full_eff = r_full;
        w_line_eff = r_line;
        if (w_hs_rise) begin
            w_ptr_eff  = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
            w_addr_eff = '0;
            w_full_eff = 1'b0;
            w_line_eff = (r_line == LINE_LAST) ? r_line : r_line + 1'b1;
        end
        w_wr      = de & ~w_full_eff;
        w_ovf_hit = de & w_full_eff;
        w_to_run  = (r_state == S_PRIME) & w_hs_rise & (r_line == PRIME_LAST);
        w_run_nxt = (r_state == S_RUN) | w_to_run;
        w_sop     = w_wr & (w_line_eff == '0) & ~r_sop_done;
    end

    // Frame/line FSM with registered outputs; vsync overrides everything once armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_full     <= 1'b0;
            r_line     <= '0;
            r_sop_done <= 1'b0;
            ram_addr   <= '0;
            ram_wen    <= '0;
            win_valid  <= 1'b0;
            frame_sop  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            ram_wen   <= '0;
            win_valid <= 1'b0;
            frame_sop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (vsync) r_state <= S_VBLANK;
                end
                default: begin
                    if (vsync) begin
                        r_state    <= S_VBLANK;
                        r_ptr      <= '0;
                        r_addr     <= '0;
                        r_full     <= 1'b0;
                        r_line     <= '0;
                        r_sop_done <= 1'b0;
                        ram_addr   <= '0;
                        ovf        <= 1'b0;
                    end else if (r_state == S_VBLANK) begin
                        r_state <= S_PRIME;
                    end else begin
                        r_ptr  <= w_ptr_eff;
                        r_line <= w_line_eff;
                        if (w_to_run) r_state <= S_RUN;
                        if (w_wr) begin
                            ram_wen  <= ROW'(onehot_ptr(3'(w_ptr_eff)));
                            ram_addr <= w_addr_eff;
                            // Last pixel: mark full and hold addr so pixel 0 is never overwritten.
                            r_full   <= (w_addr_eff == ADDR_LAST);
                            r_addr   <= (w_addr_eff == ADDR_LAST) ? w_addr_eff : w_addr_eff + 1'b1;
                        end else begin
                            r_addr <= w_addr_eff;
                            r_full <= w_full_eff;
                        end
                        if (w_ovf_hit) ovf <= 1'b1;
                        win_valid <= de & w_run_nxt;
                        if (w_sop) begin
                            frame_sop  <= 1'b1;
                            r_sop_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_sel   = r_ptr;
    assign line_cnt = r_line;

endmodule
